// File: rtl/uart_meas_fmt_if.sv
// uart_meas_fmt_if: byte handshake between the measurement formatter and
// uart_tx.
//   tx_send_o  - one-cycle send strobe (formatter -> uart_tx)
//   tx_data_o  - ASCII byte, valid while tx_send_o=1 (formatter -> uart_tx)
//   tx_ready_i - uart_tx can take a byte; drops the cycle after it samples a send
// The formatter uses the master modport and uart_tx uses the slave modport.
interface uart_meas_fmt_if;
  logic       tx_send_o;
  logic [7:0] tx_data_o;
  logic       tx_ready_i;

  modport master (output tx_send_o, output tx_data_o, input tx_ready_i);
  modport slave  (input tx_send_o, input tx_data_o, output tx_ready_i);
endinterface

// File: rtl/uart_meas_fmt.sv
// uart_meas_fmt: turns one unsigned sample into a fixed-width decimal ASCII
// line (leading zeros kept, MS digit first, then CR) and pushes it to uart_tx.
// The binary-to-BCD conversion is serial double dabble, one bit per cycle.
// Ports:
//   clk, rst_ni - system clock, asynchronous active-low reset
//   start_i     - format and send data_i; only taken while idle
//   data_i      - DATA_W-bit sample, captured when start_i is taken
//   busy_o      - a frame is converting or sending
//   done_o      - one-cycle pulse in the gap cycle after the last character
//   ovf_o       - sample did not fit in NDIG digits; held until the next start
//   tx          - uart_tx handshake (send strobe, byte, ready)
// Build option: define UART_MEAS_FMT_LF_EN to append LF after CR.
//
// state | meaning
// IDLE  | waiting for start_i
// CONV  | shift-add-3, one sample bit per cycle, DATA_W cycles
// SEND  | waiting for tx_ready_i, then strobe the current character
// GAP   | one idle cycle so uart_tx can drop ready; advance or finish
module uart_meas_fmt #(
  parameter int DATA_W = 12,
  parameter int NDIG   = 4
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ovf_o,
  uart_meas_fmt_if.master   tx
);

`ifdef UART_MEAS_FMT_LF_EN
  localparam int NCHAR = NDIG + 2;
`else
  localparam int NCHAR = NDIG + 1;
`endif
  localparam int IDX_W = $clog2(NCHAR);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * NDIG;

  localparam logic [IDX_W-1:0] IDX_CR   = IDX_W'(NDIG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHAR - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ovf_q;
  logic [3:0]        nib;
  logic [7:0]        char_sel;

  // Add-3 correction so each nibble stays a valid decimal digit after the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NDIG; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Character index 0 is the most significant digit.
  always_comb begin
    nib = 4'd0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IDX_W'(k)) nib = bcd_q[4*(NDIG-1-k) +: 4];
    end
  end

  always_comb begin
    char_sel = 8'h0D;
    if (idx_q < IDX_CR) begin
      char_sel = ovf_q ? 8'h3F : {4'h3, nib};
    end
`ifdef UART_MEAS_FMT_LF_EN
    else if (idx_q == IDX_LAST) begin
      char_sel = 8'h0A;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= S_IDLE;
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            bin_q <= data_i;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= CNT_W'(DATA_W);
            state <= S_CONV;
          end
        end
        S_CONV: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
          bin_q <= bin_q << 1;
          // A carry out of the top digit means the sample needs more digits.
          if (bcd_adj[BCD_W-1]) ovf_q <= 1'b1;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            idx_q <= '0;
            state <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx.tx_ready_i) state <= S_GAP;
        end
        S_GAP: begin
          if (idx_q == IDX_LAST) begin
            state <= S_IDLE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            state <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Send is qualified by ready directly, so a strobe can never coincide
  // with ready low and the byte is presented in the same cycle.
  assign tx.tx_send_o = (state == S_SEND) && tx.tx_ready_i;
  assign tx.tx_data_o = tx.tx_send_o ? char_sel : 8'h00;
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_GAP) && (idx_q == IDX_LAST);
  assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_uart_meas_fmt.sv
module tb_uart_meas_fmt;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start;
  logic [11:0] data;
  logic        ready;
  logic        sel;        // 0: NDIG=4 instance, 1: NDIG=3 instance
  logic        stall_en;

  always #5 clk = ~clk;

  uart_meas_fmt_if if4 ();
  uart_meas_fmt_if if3 ();
  assign if4.tx_ready_i = ready;
  assign if3.tx_ready_i = ready;

  logic start4, start3;
  logic busy4, done4, ovf4, busy3, done3, ovf3;
  assign start4 = start & ~sel;
  assign start3 = start & sel;

  uart_meas_fmt #(.DATA_W(12), .NDIG(4)) dut4 (
    .clk(clk), .rst_ni(rst_ni), .start_i(start4), .data_i(data),
    .busy_o(busy4), .done_o(done4), .ovf_o(ovf4), .tx(if4.master)
  );

  uart_meas_fmt #(.DATA_W(12), .NDIG(3)) dut3 (
    .clk(clk), .rst_ni(rst_ni), .start_i(start3), .data_i(data),
    .busy_o(busy3), .done_o(done3), .ovf_o(ovf3), .tx(if3.master)
  );

  logic       send_m, send_o, done_m, busy_m, ovf_m;
  logic [7:0] data_m;
  assign send_m = sel ? if3.tx_send_o : if4.tx_send_o;
  assign send_o = sel ? if4.tx_send_o : if3.tx_send_o;
  assign data_m = sel ? if3.tx_data_o : if4.tx_data_o;
  assign done_m = sel ? done3 : done4;
  assign busy_m = sel ? busy3 : busy4;
  assign ovf_m  = sel ? ovf3  : ovf4;

  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int done_seen = 0;
  int sent_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe pops one expected byte.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (send_m) begin
        chk("send_ready", {31'b0, ready}, 32'd1);
        if (exp_q.size() == 0) chk("extra_send", {31'b0, send_m}, 32'd0);
        else chk("tx_byte", {24'b0, data_m}, {24'b0, exp_q.pop_front()});
        sent_cnt++;
      end
      if (send_o) chk("idle_dut_send", {31'b0, send_o}, 32'd0);
      if (done_m) done_seen++;
    end
  end

  // uart_tx model: ready drops after each sampled send, stays low 20 cycles.
  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_ni && send_m && stall_en) begin
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (20) @(posedge clk);
        #1 ready = 1'b1;
      end
    end
  end

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  task automatic push_frame(input int v);
    int nd;
    nd = sel ? 3 : 4;
    for (int i = 0; i < nd; i++) begin
      if (v >= pow10(nd)) exp_q.push_back(8'h3F);
      else exp_q.push_back(8'(32'h30 + (v / pow10(nd - 1 - i)) % 10));
    end
    exp_q.push_back(8'h0D);
`ifdef UART_MEAS_FMT_LF_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic drive_start(input int v);
    push_frame(v);
    done_seen = 0;
    sent_cnt = 0;
    @(posedge clk);
    #1 start = 1'b1; data = 12'(v);
    @(posedge clk);
    #1 start = 1'b0; data = 12'($urandom);
  endtask

  // Called just after the accept edge; checks first strobe lands DATA_W+1 edges later.
  task automatic wait_first_send(input bit chk_lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!send_m && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!send_m) chk("first_send_timeout", 32'd0, 32'd1);
    else if (chk_lat) chk("first_send_lat", 32'(n + 1), 32'd13);
  endtask

  // chain >= 0: offer a start in the done cycle (must be ignored) and then
  // start 'chain' in the following cycle (must be taken).
  task automatic wait_done(input int v, input int chain);
    int n;
    n = 0;
    while (!done_m && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!done_m) begin
      chk("done_timeout", 32'd0, 32'd1);
      return;
    end
    chk("busy_at_done", {31'b0, busy_m}, 32'd1);
    chk("ovf", {31'b0, ovf_m}, {31'b0, (v >= pow10(sel ? 3 : 4))});
    chk("queue_empty_at_done", 32'(exp_q.size()), 32'd0);
    if (chain >= 0) begin
      start = 1'b1; data = 12'd111;
      @(posedge clk);
      chk("done_count", 32'(done_seen), 32'd1);
      push_frame(chain);
      done_seen = 0;
      #1 data = 12'(chain);
      @(posedge clk);
      #1 start = 1'b0; data = 12'($urandom);
    end else begin
      @(posedge clk);
      @(negedge clk);
      chk("busy_after_done", {31'b0, busy_m}, 32'd0);
      chk("done_pulse_len", {31'b0, done_m}, 32'd0);
      chk("done_count", 32'(done_seen), 32'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'b0, busy4}, 32'd0);
    chk({tag, "_done"}, {31'b0, done4}, 32'd0);
    chk({tag, "_ovf"},  {31'b0, ovf4},  32'd0);
    chk({tag, "_send"}, {31'b0, if4.tx_send_o}, 32'd0);
    chk({tag, "_data"}, {24'b0, if4.tx_data_o}, 32'd0);
  endtask

  initial begin
    int n;
    rst_ni = 1'b0; start = 1'b0; data = '0; sel = 1'b0; stall_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    @(posedge clk);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk);

    // Nominal frame, ready always high.
    drive_start(1234);
    wait_first_send(1'b1);
    wait_done(1234, -1);

    // Zero, then full scale started in the cycle after done.
    drive_start(0);
    wait_first_send(1'b1);
    wait_done(0, 4095);
    wait_first_send(1'b1);
    wait_done(4095, -1);

    // Three-digit instance: overflow and largest fitting value.
    sel = 1'b1;
    drive_start(1000);
    wait_first_send(1'b1);
    wait_done(1000, -1);
    drive_start(999);
    wait_first_send(1'b1);
    wait_done(999, -1);
    sel = 1'b0;

    // Slow uart_tx plus a stray start mid-frame.
    stall_en = 1'b1;
    drive_start(3070);
    wait_first_send(1'b0);
    @(posedge clk);
    #1 start = 1'b1; data = 12'd1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(3070, -1);
    repeat (30) @(negedge clk);
    chk("no_restart", {31'b0, busy4}, 32'd0);

    // Reset after the second character.
    drive_start(2468);
    n = 0;
    while (sent_cnt < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("two_chars_sent", 32'(sent_cnt >= 2), 32'd1);
    chk("busy_pre_rst", {31'b0, busy4}, 32'd1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("async_rst");
    exp_q.delete();
    repeat (25) @(posedge clk);
    #1 rst_ni = 1'b1;
    stall_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_idle", {31'b0, busy4}, 32'd0);
    chk("post_rst_sends", 32'(sent_cnt), 32'd2);
    drive_start(42);
    wait_first_send(1'b1);
    wait_done(42, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
